// File: rtl/div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient reported for a zero divisor (all ones).
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : div_seq_ctrl_if
//  Description : Request/result bundle between the control unit (master)
//                and the sequential divider (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One non-restoring division iteration (combinational).
//                The partial remainder is one bit wider than the operands so
//                that divisors with the MSB set do not overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] w_a_shift;
  logic [WIDTH:0] w_m_ext;

  // Shift {A,Q} left, then add or subtract M depending on the pre-shift sign of A.
  always_comb begin
    w_a_shift = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
    w_m_ext   = {1'b0, m_i};
    a_o       = a_i[WIDTH] ? (w_a_shift + w_m_ext) : (w_a_shift - w_m_ext);
    q_o       = {q_i[WIDTH-2:0], ~a_o[WIDTH]};
  end

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : div_seq_ctrl
//  Description : Multi-cycle non-restoring divider sequencer, one iteration
//                per clock. Results (LO=quotient, HI=remainder) are
//                registered on entry to DONE and held until the next
//                completion.
//  Config      : DIV_SIGNED_EN - two's complement operands (magnitude divide
//                plus sign fix-up in FIX); undefined gives unsigned divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clock,
  input  logic           reset_n,
  div_seq_ctrl_if.slave  bus
);

  localparam logic [WIDTH-1:0] DIV0_Q   = {WIDTH{DIV0_QUOTIENT[0]}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             w_ready;
  logic             w_accept;
  logic             w_div0;
  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_abs;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // A request is only looked at when no operation is in flight.
  assign w_ready  = (state_q == IDLE) || (state_q == DONE);
  assign w_accept = w_ready && bus.start && (bus.divisor != '0);
  assign w_div0   = w_ready && bus.start && (bus.divisor == '0);

  // Final remainder restore: a negative partial remainder gets M added back.
  assign w_rem_abs = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (qr_q),
    .m_i (m_q),
    .a_o (w_a_next),
    .q_o (w_q_next)
  );

`ifdef DIV_SIGNED_EN
  logic qneg_q;
  logic rneg_q;

  assign w_dvd_mag  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_dvs_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign w_quot_fix = qneg_q ? -qr_q      : qr_q;
  assign w_rem_fix  = rneg_q ? -w_rem_abs : w_rem_abs;

  // Capture the result signs with the operands; remainder follows the dividend.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (w_accept) begin
      qneg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      rneg_q <= bus.dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_mag  = bus.dividend;
  assign w_dvs_mag  = bus.divisor;
  assign w_quot_fix = qr_q;
  assign w_rem_fix  = w_rem_abs;
`endif

  // State, datapath and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      qr_q    <= '0;
      m_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      m_q     <= m_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept/iterate/fix-up, results loaded only on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    qr_d    = qr_q;
    m_d     = m_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (w_accept) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = '0;
          qr_d    = w_dvd_mag;
          m_d     = w_dvs_mag;
        end else if (w_div0) begin
          state_d = DONE;
          quot_d  = DIV0_Q;
          rem_d   = bus.dividend;
          dbz_d   = 1'b1;
        end
      end
      RUN: begin
        a_d   = w_a_next;
        qr_d  = w_q_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        quot_d  = w_quot_fix;
        rem_d   = w_rem_fix;
        dbz_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q == RUN) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq_ctrl
//  Description : Scoreboard bench for div_seq_ctrl. Stimulus pushes the
//                hand-computed result and done cycle; a monitor pops and
//                compares on every done pulse.
//  Config      : DIV_SIGNED_EN selects the signed expectation set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   busy_cnt;
  exp_t sb[$];
  exp_t e;

  div_seq_ctrl_if #(.WIDTH(32)) dif ();

  div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (dif.busy === 1'b1) busy_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (dif.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient",    dif.quotient,            e.q);
        check("remainder",   dif.remainder,           e.r);
        check("div_by_zero", {31'b0, dif.div_by_zero}, {31'b0, e.dbz});
        check("done_cycle",  cyc,                     e.cyc);
      end
    end
  end

  // Drive a request at the current negedge; the accepting edge is the next posedge.
  task automatic issue_now(input logic [31:0] dvd, input logic [31:0] dvs,
                           input logic [31:0] qe, input logic [31:0] re,
                           input logic de, input int lat, input bit push);
    exp_t x;
    dif.start    = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    if (push) begin
      x.q = qe; x.r = re; x.dbz = de; x.cyc = cyc + lat;
      sb.push_back(x);
    end
    @(negedge clock);
    dif.start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs,
                       input logic [31:0] qe, input logic [31:0] re,
                       input logic de, input int lat, input bit push);
    @(negedge clock);
    issue_now(dvd, dvs, qe, re, de, lat, push);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (dif.busy === 1'b0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clock);
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: got busy=%b pending=%0d after 200 cycles, expected idle", dif.busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
    if (cyc != t) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_cyc: got cycle %0d, expected %0d", cyc, t);
    end
  endtask

  int s;

  initial begin
    cyc          = 0;
    n_vec        = 0;
    n_err        = 0;
    busy_cnt     = 0;
    reset_n      = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'b0, dif.busy},        32'd0);
    check("rst_done", {31'b0, dif.done},        32'd0);
    check("rst_quot", dif.quotient,             32'd0);
    check("rst_rem",  dif.remainder,            32'd0);
    check("rst_dbz",  {31'b0, dif.div_by_zero}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 100/7, operands disturbed while running
    busy_cnt = 0;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b1);
    dif.dividend = 32'hDEAD_BEEF;
    dif.divisor  = 32'd0;
    wait_idle();
    check("busy_cycles", busy_cnt, 32'd33);

    // divisor with MSB set
`ifdef DIV_SIGNED_EN
    issue(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);
`else
    issue(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 34, 1'b1);
`endif
    wait_idle();

    // divide by zero, then a normal divide clears the flag
    issue(32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1, 1'b1);
    wait_idle();
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 1'b1);
    wait_idle();

    // start while busy is ignored; back-to-back start in the DONE cycle is taken
    issue(32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 34, 1'b1);
    s = cyc - 1;
    wait_cyc(s + 5);
    dif.start    = 1'b1;
    dif.dividend = 32'd1;
    dif.divisor  = 32'd1;
    @(negedge clock);
    dif.start = 1'b0;
    wait_cyc(s + 34);
    check("b2b_done_seen", {31'b0, dif.done}, 32'd1);
    issue_now(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 34, 1'b1);
    wait_idle();

    // asynchronous reset mid-operation
    issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    s = cyc - 1;
    wait_cyc(s + 10);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, dif.busy},        32'd0);
    check("abort_done", {31'b0, dif.done},        32'd0);
    check("abort_quot", dif.quotient,             32'd0);
    check("abort_rem",  dif.remainder,            32'd0);
    check("abort_dbz",  {31'b0, dif.div_by_zero}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34, 1'b1);
    wait_idle();

    // sign handling
`ifdef DIV_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 1'b1);
    wait_idle();
`else
    issue(32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, 1'b1);
    wait_idle();
`endif
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 1'b1);
    wait_idle();
    issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 34, 1'b1);
    wait_idle();

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
